axi4_slave_neural_mem: RTL and testbench
========================================

// Module: axi4_slave_neural_mem
// PURPOSE
//  AXI4 (full) memory responder: the slave end of the neural accelerator's AXI4 master port.
//  Holds input, weight and output tensors in an internal word-addressed RAM and serves
//  independent read and write bursts. Serves as the on-chip scratch memory and the
//  bench-side memory model.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  64     data bus width in bits; only 64 is supported
//  C_S_AXI_ADDR_WIDTH  32     address bus width in bits
//  MEM_DEPTH_WORDS     4096   RAM depth in 64-bit words; must be a power of 2
//  BASE_ADDR           32'h0  byte address of word 0; must be aligned to MEM_DEPTH_WORDS*8
// PORTS
//  S_AXI_ACLK     in   1    clock; all logic is on the rising edge
//  S_AXI_ARESETN  in   1    asynchronous, active-low reset
//  S_AXI_AWADDR   in   32   write burst start byte address
//  S_AXI_AWLEN    in   8    write beats minus 1
//  S_AXI_AWSIZE   in   3    log2 bytes per beat
//  S_AXI_AWBURST  in   2    burst type; only INCR (2'b01) is supported
//  S_AXI_AWVALID  in   1    write address valid
//  S_AXI_AWREADY  out  1    write address ready
//  S_AXI_WDATA    in   64   write data
//  S_AXI_WSTRB    in   8    byte-lane write enables
//  S_AXI_WLAST    in   1    last write beat
//  S_AXI_WVALID   in   1    write data valid
//  S_AXI_WREADY   out  1    write data ready
//  S_AXI_BRESP    out  2    write response
//  S_AXI_BVALID   out  1    write response valid
//  S_AXI_BREADY   in   1    write response ready
//  S_AXI_ARADDR   in   32   read burst start byte address
//  S_AXI_ARLEN    in   8    read beats minus 1
//  S_AXI_ARSIZE   in   3    log2 bytes per beat
//  S_AXI_ARBURST  in   2    burst type; only INCR is supported
//  S_AXI_ARVALID  in   1    read address valid
//  S_AXI_ARREADY  out  1    read address ready
//  S_AXI_RDATA    out  64   read data
//  S_AXI_RRESP    out  2    read response, per beat
//  S_AXI_RLAST    out  1    last read beat
//  S_AXI_RVALID   out  1    read data valid
//  S_AXI_RREADY   in   1    read data ready
// BEHAVIOUR
//  Reset values: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP, RDATA = 0.
//   RAM is not reset. Asserting reset mid-burst aborts the burst: both FSMs go to IDLE and no
//   further beats or responses are issued for it.
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE (AWREADY=1): AW handshake latches addr, len, size, burst and clears the beat count.
//   - W_DATA (WREADY=1): on each W handshake, bytes with WSTRB=1 are written to
//     mem[(addr-BASE_ADDR)>>3], then addr += 1<<size and the beat count increments.
//   - Leave W_DATA on the beat where count==len; BVALID rises the next cycle.
//   - W_RESP (BVALID=1, BRESP held stable): exit on BREADY. AWREADY is low until W_IDLE.
//  Read FSM R_IDLE -> R_DATA:
//   - AR handshake at edge N gives RVALID=1 with beat 0 at edge N+1 (1-cycle RAM latency).
//   - RDATA, RRESP and RLAST are held stable while RVALID & !RREADY.
//   - While RREADY=1, one beat per cycle with no bubbles. RLAST=1 on beat len.
//   - Return to R_IDLE (ARREADY=1) on the cycle after the last R handshake.
//  Read and write channels are fully independent; each has one outstanding burst.
//   Same-word read and write in one cycle: the read returns the old data (read-first).
//  Errors (the burst still completes with the full beat count):
//   - SLVERR (2'b10): burst != INCR, size > 3, or WLAST value != (count==len) on any beat.
//   - DECERR (2'b11): any beat address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH_WORDS*8).
//   - Erroring write beats are dropped; erroring read beats return RDATA=0.
//   - BRESP is the worst error seen across the burst (DECERR > SLVERR > OKAY).
//   - RRESP is per beat.
//  Address arithmetic is 32-bit and wraps modulo 2^32. A 4 KB boundary crossing is not checked.
//   Narrow transfers (size<3) use the lanes selected by WSTRB; RDATA always returns the full word.
// TESTING
//  1. Write 0x1111..0x4444, AWLEN=3 @0x100, BREADY=1; read back ARLEN=3 -> 4 beats in order,
//     RLAST on beat 3, BRESP=RRESP=0.
//  2. Read ARLEN=7 with RREADY toggling 1,0,1,0 -> RDATA stable while stalled, 8 beats,
//     RLAST on beat 7 only.
//  3. Write 0xFFFF_FFFF_FFFF_FFFF then WSTRB=8'h0F with 0 -> read back 0xFFFF_FFFF_0000_0000.
//  4. AWBURST=WRAP, then AWADDR=BASE+MEM_DEPTH_WORDS*8 -> BRESP=2 then 3, RAM unchanged.
//  5. WLAST asserted on beat 1 of AWLEN=3 -> 4 beats accepted, BRESP=2.
//  6. Reset pulsed mid read burst -> RVALID=0 the same cycle (asynchronous reset),
//     ARREADY=1 after release, next burst correct.

Source files
------------

// File: rtl/axi4_slave_neural_mem.sv
// AXI4 (full) memory responder for the neural accelerator: word-addressed RAM with
// independent INCR read and write burst engines and per-beat error decode.
module axi4_slave_neural_mem #(
    parameter int                              C_S_AXI_DATA_WIDTH = 64,
    parameter int                              C_S_AXI_ADDR_WIDTH = 32,
    parameter int                              MEM_DEPTH_WORDS    = 4096,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = 32'h0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(MEM_DEPTH_WORDS);
    localparam logic [AW-1:0] MEM_BYTES = AW'(MEM_DEPTH_WORDS * 8);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Response codes are ordered so that the numerically larger one is the worse one.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        worst_resp = (a > b) ? a : b;
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH_WORDS];
    logic [DW-1:0] mem_rd_q;

    w_state_e      w_state_q, w_state_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [7:0]    w_len_q, w_len_d;
    logic [7:0]    w_cnt_q, w_cnt_d;
    logic [2:0]    w_size_q, w_size_d;
    logic [1:0]    w_burst_q, w_burst_d;
    logic [1:0]    w_err_q, w_err_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          mem_we;

    r_state_e      r_state_q, r_state_d;
    logic [AW-1:0] r_addr_q, r_addr_d;
    logic [7:0]    r_len_q, r_len_d;
    logic [7:0]    r_cnt_q, r_cnt_d;
    logic [2:0]    r_size_q, r_size_d;
    logic [1:0]    r_burst_q, r_burst_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          rzero_q, rzero_d;
    logic          rd_en;

    logic [AW-1:0] w_off;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_beat_err;
    logic [AW-1:0] r_fetch_addr;
    logic [2:0]    r_fetch_size;
    logic [1:0]    r_fetch_burst;
    logic [AW-1:0] r_off;
    logic [IW-1:0] r_idx;
    logic [1:0]    r_beat_err;

    assign w_off = w_addr_q - BASE_ADDR;
    assign w_idx = w_off[IW+2:3];
    assign w_beat_err = (w_off >= MEM_BYTES) ? RESP_DECERR :
                        ((w_burst_q != BURST_INCR) || (w_size_q > 3'd3) ||
                         (S_AXI_WLAST != (w_cnt_q == w_len_q))) ? RESP_SLVERR : RESP_OKAY;

    // The read port is addressed straight from AR while idle so beat 0 lands one cycle after AR.
    assign r_fetch_addr  = (r_state_q == R_IDLE) ? S_AXI_ARADDR  : r_addr_q;
    assign r_fetch_size  = (r_state_q == R_IDLE) ? S_AXI_ARSIZE  : r_size_q;
    assign r_fetch_burst = (r_state_q == R_IDLE) ? S_AXI_ARBURST : r_burst_q;
    assign r_off = r_fetch_addr - BASE_ADDR;
    assign r_idx = r_off[IW+2:3];
    assign r_beat_err = (r_off >= MEM_BYTES) ? RESP_DECERR :
                        ((r_fetch_burst != BURST_INCR) || (r_fetch_size > 3'd3)) ? RESP_SLVERR
                                                                                 : RESP_OKAY;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID) begin
                    w_addr_d  = S_AXI_AWADDR;
                    w_len_d   = S_AXI_AWLEN;
                    w_size_d  = S_AXI_AWSIZE;
                    w_burst_d = S_AXI_AWBURST;
                    w_cnt_d   = 8'd0;
                    w_err_d   = RESP_OKAY;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    mem_we   = (w_beat_err == RESP_OKAY);
                    w_addr_d = w_addr_q + (AW'(1) << w_size_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    w_err_d  = worst_resp(w_err_q, w_beat_err);
                    if (w_cnt_q == w_len_q) begin
                        bresp_d   = worst_resp(w_err_q, w_beat_err);
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rzero_d   = rzero_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rd_en     = 1'b1;
                    r_len_d   = S_AXI_ARLEN;
                    r_size_d  = S_AXI_ARSIZE;
                    r_burst_d = S_AXI_ARBURST;
                    r_addr_d  = S_AXI_ARADDR + (AW'(1) << S_AXI_ARSIZE);
                    r_cnt_d   = 8'd0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (S_AXI_ARLEN == 8'd0);
                    rresp_d   = r_beat_err;
                    rzero_d   = (r_beat_err != RESP_OKAY);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_en    = 1'b1;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_addr_d = r_addr_q + (AW'(1) << r_size_q);
                        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                        rresp_d  = r_beat_err;
                        rzero_d  = (r_beat_err != RESP_OKAY);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_err_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rzero_q   <= 1'b1;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rzero_q   <= rzero_d;
        end
    end

    // Read-first RAM: a same-edge write to the word being read is seen only by later reads.
    always_ff @(posedge S_AXI_ACLK) begin
        if (rd_en) begin
            mem_rd_q <= mem[r_idx];
        end
        if (mem_we) begin
            for (int b = 0; b < SW; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                end
            end
        end
    end

    assign S_AXI_AWREADY = (w_state_q == W_IDLE);
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rzero_q ? '0 : mem_rd_q;

endmodule

// File: tb/tb_axi4_slave_neural_mem.sv
// Directed bench for axi4_slave_neural_mem: a table of single-beat write/read vectors
// followed by hand-written burst, stall, error and mid-burst reset sequences.
module tb_axi4_slave_neural_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    always #5 clk = ~clk;

    axi4_slave_neural_mem dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWSIZE  (awsize),
        .S_AXI_AWBURST (awburst),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] WRAP = 2'b10;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [1:0]  exp_bresp;
        logic [63:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] wbuf  [16];
    logic [63:0] rbuf  [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] strb, input int last_beat, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", 64'(awready), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chk("w_ready", 64'(wready), 64'd1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("b_valid", 64'(bvalid), 64'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
        $display("WR addr=%h len=%0d burst=%0d strb=%h bresp=%0d", addr, len, burst, strb, resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle);
        int          n, beat, cyc;
        logic        stalled;
        logic [63:0] held;
        @(negedge clk);
        araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_first_beat_latency", 64'(rvalid), 64'd1);
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beat <= int'(len) && cyc < 200) begin
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (rvalid === 1'b1) begin
                if (stalled) chk("r_stall_hold", rdata, held);
                if (rready) begin
                    if (beat < 16) begin
                        rbuf[beat] = rdata; rrbuf[beat] = rresp; rlbuf[beat] = rlast;
                    end
                    beat++;
                    stalled = 1'b0;
                end else begin
                    held = rdata;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        chk("r_beat_count", 64'(beat), 64'(int'(len) + 1));
        chk("r_done_arready", 64'(arready), 64'd1);
        chk("r_done_rvalid", 64'(rvalid), 64'd0);
        $display("RD addr=%h len=%0d burst=%0d beat0=%h rresp0=%0d", addr, len, burst, rbuf[0], rrbuf[0]);
    endtask

    vec_t        vecs [8];
    logic [1:0]  resp;
    logic [63:0] exp_w;

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        vecs[0] = '{32'h0000_0000, 64'hDEAD_BEEF_0123_4567, 8'hFF, 2'd0, 64'hDEAD_BEEF_0123_4567, 2'd0};
        vecs[1] = '{32'h0000_7FF8, 64'hA5A5_5A5A_C3C3_3C3C, 8'hFF, 2'd0, 64'hA5A5_5A5A_C3C3_3C3C, 2'd0};
        vecs[2] = '{32'h0000_8000, 64'h0000_0000_0000_1234, 8'hFF, 2'd3, 64'h0, 2'd3};
        vecs[3] = '{32'h0000_0208, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
        vecs[4] = '{32'h0000_0208, 64'h0000_0000_0000_0000, 8'h0F, 2'd0, 64'hFFFF_FFFF_0000_0000, 2'd0};
        vecs[5] = '{32'hFFFF_FFF8, 64'h0000_0000_0000_0055, 8'hFF, 2'd3, 64'h0, 2'd3};
        vecs[6] = '{32'h0000_0210, 64'h0102_0304_0506_0708, 8'hFF, 2'd0, 64'h0102_0304_0506_0708, 2'd0};
        vecs[7] = '{32'h0000_0210, 64'hAAAA_AAAA_AAAA_AAAA, 8'h3C, 2'd0, 64'h0102_AAAA_AAAA_0708, 2'd0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_wready",  64'(wready),  64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_rlast",   64'(rlast),   64'd0);
        chk("rst_bresp",   64'(bresp),   64'd0);
        chk("rst_rresp",   64'(rresp),   64'd0);
        chk("rst_rdata",   rdata,        64'd0);

        for (int v = 0; v < 8; v++) begin
            wbuf[0] = vecs[v].wdata;
            do_write(vecs[v].addr, 8'd0, INCR, vecs[v].strb, 0, resp);
            chk("vec_bresp", 64'(resp), 64'(vecs[v].exp_bresp));
            do_read(vecs[v].addr, 8'd0, INCR, 1'b0);
            chk("vec_rdata", rbuf[0], vecs[v].exp_rdata);
            chk("vec_rresp", 64'(rrbuf[0]), 64'(vecs[v].exp_rresp));
            chk("vec_rlast", 64'(rlbuf[0]), 64'd1);
        end

        // Four-beat burst round trip.
        for (int i = 0; i < 4; i++) wbuf[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        do_write(32'h100, 8'd3, INCR, 8'hFF, 3, resp);
        chk("t1_bresp", 64'(resp), 64'd0);
        do_read(32'h100, 8'd3, INCR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rdata", rbuf[i], 64'h1111_1111_1111_1111 * 64'(i + 1));
            chk("t1_rresp", 64'(rrbuf[i]), 64'd0);
            chk("t1_rlast", 64'(rlbuf[i]), 64'(i == 3));
        end

        // Eight-beat read under a toggling RREADY.
        for (int i = 0; i < 8; i++) wbuf[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
        do_write(32'h400, 8'd7, INCR, 8'hFF, 7, resp);
        chk("t2_bresp", 64'(resp), 64'd0);
        do_read(32'h400, 8'd7, INCR, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_rdata", rbuf[i], 64'h0101_0101_0101_0101 * 64'(i + 1));
            chk("t2_rlast", 64'(rlbuf[i]), 64'(i == 7));
        end

        // WRAP bursts are rejected; decoded-out writes must not alias onto low or high words.
        wbuf[0] = 64'h0000_0000_0000_0BAD;
        do_write(32'h100, 8'd0, WRAP, 8'hFF, 0, resp);
        chk("t4_wrap_bresp", 64'(resp), 64'd2);
        do_read(32'h100, 8'd0, INCR, 1'b0);
        chk("t4_wrap_unchanged", rbuf[0], 64'h1111_1111_1111_1111);
        do_read(32'h0, 8'd0, INCR, 1'b0);
        chk("t4_decerr_no_alias_lo", rbuf[0], 64'hDEAD_BEEF_0123_4567);
        do_read(32'h7FF8, 8'd0, INCR, 1'b0);
        chk("t4_decerr_no_alias_hi", rbuf[0], 64'hA5A5_5A5A_C3C3_3C3C);
        do_read(32'h100, 8'd1, WRAP, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("t4_wrap_rresp", 64'(rrbuf[i]), 64'd2);
            chk("t4_wrap_rdata", rbuf[i], 64'd0);
            chk("t4_wrap_rlast", 64'(rlbuf[i]), 64'(i == 1));
        end
        do_read(32'h7FF8, 8'd1, INCR, 1'b0);
        chk("t4_cross_rresp0", 64'(rrbuf[0]), 64'd0);
        chk("t4_cross_rresp1", 64'(rrbuf[1]), 64'd3);
        chk("t4_cross_rdata1", rbuf[1], 64'd0);

        // Early WLAST: all four beats taken, mismatching beats (1 and 3) dropped.
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hC000_0000_0000_0000 + 64'(i);
        do_write(32'h600, 8'd3, INCR, 8'hFF, 3, resp);
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hD000_0000_0000_0000 + 64'(i);
        do_write(32'h600, 8'd3, INCR, 8'hFF, 1, resp);
        chk("t5_bresp", 64'(resp), 64'd2);
        do_read(32'h600, 8'd3, INCR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_w = ((i % 2) == 0) ? 64'hD000_0000_0000_0000 + 64'(i) : 64'hC000_0000_0000_0000 + 64'(i);
            chk("t5_rdata", rbuf[i], exp_w);
        end

        // Reset in the middle of a read burst.
        @(negedge clk);
        araddr = 32'h400; arlen = 8'd7; arsize = 3'd3; arburst = INCR; arvalid = 1'b1;
        chk("t6_arready", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        chk("t6_rvalid_before", 64'(rvalid), 64'd1);
        repeat (2) @(negedge clk);
        rready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid_async", 64'(rvalid), 64'd0);
        chk("t6_rdata_async", rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_arready_after", 64'(arready), 64'd1);
        chk("t6_awready_after", 64'(awready), 64'd1);
        chk("t6_rvalid_after", 64'(rvalid), 64'd0);
        $display("RST mid-burst at addr=00000400 rvalid=%0d arready=%0d", rvalid, arready);
        do_read(32'h400, 8'd1, INCR, 1'b0);
        chk("t6_rdata0", rbuf[0], 64'h0101_0101_0101_0101);
        chk("t6_rdata1", rbuf[1], 64'h0202_0202_0202_0202);
        chk("t6_rlast1", 64'(rlbuf[1]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
